pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard controller for a five-stage in-order pipeline.
//   Decides per-stage stall/flush from reset, cache misses, load-use hazards
//   and control transfers, selects E-stage operand forwarding, and keeps
//   saturating stall/flush performance counters.
// Ports:
//   clk, CpuRst                    clock, synchronous active-high reset
//   ICacheMiss, DCacheMiss         cache miss in progress (stall everything)
//   BranchE, JalrE, JalD           taken branch/jalr in E, jal decoded in D
//   Rs1D/Rs2D/Rs1E/Rs2E/RdE/RdM/RdW register numbers per stage
//   RegReadD/E [1]=rs1 used [0]=rs2 used
//   MemToRegE, RegWriteM/W         nonzero = load in E / write-back pending
//   Stall*/Flush*                  per-stage pipeline control
//   Forward1E/2E                   2'b10 from M, 2'b01 from W, 2'b00 regfile
//   LdUseBusy                      load-use bubble sequence in progress
//   PerfStallCnt/PerfFlushCnt      saturating counters of StallF/FlushD cycles

// One operand's forwarding select; the newest producer (M) wins over W.
module phc_fwd_unit #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic             used,
  input  logic [REG_W-1:0] rdm,
  input  logic             wrm,
  input  logic [REG_W-1:0] rdw,
  input  logic             wrw,
  output logic [1:0]       fwd
);
  always_comb begin
    fwd = 2'b00;
    if (used && wrm && rdm != '0 && rdm == rs)      fwd = 2'b10;
    else if (used && wrw && rdw != '0 && rdw == rs) fwd = 2'b01;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int REG_W          = 5,
  parameter int LD_USE_BUBBLES = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             CpuRst,
  input  logic             ICacheMiss,
  input  logic             DCacheMiss,
  input  logic             BranchE,
  input  logic             JalrE,
  input  logic             JalD,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic [1:0]       RegReadD,
  input  logic [1:0]       RegReadE,
  input  logic [2:0]       MemToRegE,
  input  logic [2:0]       RegWriteM,
  input  logic [2:0]       RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushF,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       Forward1E,
  output logic [1:0]       Forward2E,
  output logic             LdUseBusy,
  output logic [CNT_W-1:0] PerfStallCnt,
  output logic [CNT_W-1:0] PerfFlushCnt
);
  // Detect cycle is the first bubble, so the counter holds the remainder.
  localparam logic [1:0] BUB_INIT = 2'(LD_USE_BUBBLES - 1);

  // Stage order in the packed vectors: [4]=F [3]=D [2]=E [1]=M [0]=W.
  logic [4:0] stall, flush;
  logic [1:0] bub_q, bub_d;
  logic       miss, ld_use, bub_act;

  assign miss    = ICacheMiss | DCacheMiss;
  assign bub_act = (bub_q != 2'd0);
  assign ld_use  = (MemToRegE != 3'd0) && (RdE != '0) &&
                   ((RdE == Rs1D && RegReadD[1]) || (RdE == Rs2D && RegReadD[0]));

  always_comb begin
    stall = 5'b00000;
    flush = 5'b00000;
    bub_d = bub_q;
    if (CpuRst) begin
      flush = 5'b11111;
      bub_d = 2'd0;
    end else if (miss) begin
      // Freeze the whole pipe; a pending bubble count is held, not consumed.
      stall = 5'b11111;
    end else if (bub_act) begin
      stall = 5'b11000;
      flush = 5'b00100;
      bub_d = bub_q - 2'd1;
    end else if (ld_use) begin
      stall = 5'b11000;
      flush = 5'b00100;
      bub_d = BUB_INIT;
    end else if (BranchE | JalrE) begin
      flush = 5'b01100;
    end else if (JalD) begin
      flush = 5'b01000;
    end
  end

  assign {StallF, StallD, StallE, StallM, StallW} = stall;
  assign {FlushF, FlushD, FlushE, FlushM, FlushW} = flush;
  assign LdUseBusy = bub_act;

  always_ff @(posedge clk) begin
    if (CpuRst) begin
      bub_q        <= 2'd0;
      PerfStallCnt <= '0;
      PerfFlushCnt <= '0;
    end else begin
      bub_q <= bub_d;
      if (StallF && PerfStallCnt != '1) PerfStallCnt <= PerfStallCnt + CNT_W'(1);
      if (FlushD && PerfFlushCnt != '1) PerfFlushCnt <= PerfFlushCnt + CNT_W'(1);
    end
  end

  // Operand index 1 = rs1, 0 = rs2, matching the RegReadE bit order.
  logic [1:0][REG_W-1:0] rs_e;
  logic [1:0][1:0]       fwd;
  assign rs_e = {Rs1E, Rs2E};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    phc_fwd_unit #(.REG_W(REG_W)) u_fwd (
      .rs  (rs_e[i]),
      .used(RegReadE[i]),
      .rdm (RdM),
      .wrm (RegWriteM != 3'd0),
      .rdw (RdW),
      .wrw (RegWriteW != 3'd0),
      .fwd (fwd[i])
    );
  end

  assign Forward1E = fwd[1];
  assign Forward2E = fwd[0];
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, im, dm, be, je, jd;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0] rrd, rre;
  logic [2:0] m2r, rwm, rww;

  // u1: one bubble, 4-bit counters. u3: three bubbles, 32-bit counters.
  logic [4:0]  st1, fl1, st3, fl3;
  logic [1:0]  f11, f21, f13, f23;
  logic        b1, b3;
  logic [3:0]  sc1, fc1;
  logic [31:0] sc3, fc3;

  pipe_hazard_ctrl #(.REG_W(5), .LD_USE_BUBBLES(1), .CNT_W(4)) u1 (
    .clk(clk), .CpuRst(rst), .ICacheMiss(im), .DCacheMiss(dm),
    .BranchE(be), .JalrE(je), .JalD(jd),
    .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e), .RdE(rde), .RdM(rdm), .RdW(rdw),
    .RegReadD(rrd), .RegReadE(rre), .MemToRegE(m2r), .RegWriteM(rwm), .RegWriteW(rww),
    .StallF(st1[4]), .StallD(st1[3]), .StallE(st1[2]), .StallM(st1[1]), .StallW(st1[0]),
    .FlushF(fl1[4]), .FlushD(fl1[3]), .FlushE(fl1[2]), .FlushM(fl1[1]), .FlushW(fl1[0]),
    .Forward1E(f11), .Forward2E(f21), .LdUseBusy(b1), .PerfStallCnt(sc1), .PerfFlushCnt(fc1));

  pipe_hazard_ctrl #(.REG_W(5), .LD_USE_BUBBLES(3), .CNT_W(32)) u3 (
    .clk(clk), .CpuRst(rst), .ICacheMiss(im), .DCacheMiss(dm),
    .BranchE(be), .JalrE(je), .JalD(jd),
    .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e), .RdE(rde), .RdM(rdm), .RdW(rdw),
    .RegReadD(rrd), .RegReadE(rre), .MemToRegE(m2r), .RegWriteM(rwm), .RegWriteW(rww),
    .StallF(st3[4]), .StallD(st3[3]), .StallE(st3[2]), .StallM(st3[1]), .StallW(st3[0]),
    .FlushF(fl3[4]), .FlushD(fl3[3]), .FlushE(fl3[2]), .FlushM(fl3[1]), .FlushW(fl3[0]),
    .Forward1E(f13), .Forward2E(f23), .LdUseBusy(b3), .PerfStallCnt(sc3), .PerfFlushCnt(fc3));

  typedef struct {
    logic       rst, im, dm, be, je, jd;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rrd, rre;
    logic [2:0] m2r, rwm, rww;
    logic [4:0] stall, flush;  // {F,D,E,M,W}
    logic [1:0] f1, f2;
  } vec_t;

  vec_t tbl[$];
  vec_t v, z;
  int   nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    rst = x.rst; im = x.im; dm = x.dm; be = x.be; je = x.je; jd = x.jd;
    rs1d = x.rs1d; rs2d = x.rs2d; rs1e = x.rs1e; rs2e = x.rs2e;
    rde = x.rde; rdm = x.rdm; rdw = x.rdw;
    rrd = x.rrd; rre = x.rre; m2r = x.m2r; rwm = x.rwm; rww = x.rww;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    apply(z); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // Load-use: load to x5 in E, D reads x5 as rs1.
  task automatic set_lduse();
    m2r = 3'd1; rde = 5'd5; rs1d = 5'd5; rrd = 2'b10;
  endtask

  initial begin
    z = '{default: '0};
    apply(z); rst = 1'b1;
    tick(); tick();

    // reset state
    v = z; v.rst = 1; v.flush = 5'b11111; tbl.push_back(v);
    v = z; tbl.push_back(v);
    // forwarding still live during reset
    v = z; v.rst = 1; v.rwm = 1; v.rdm = 7; v.rs1e = 7; v.rre = 2'b11;
    v.flush = 5'b11111; v.f1 = 2'b10; tbl.push_back(v);
    // M beats W, then W, then regfile
    v = z; v.rwm = 1; v.rdm = 7; v.rww = 1; v.rdw = 7; v.rs1e = 7; v.rre = 2'b11; v.f1 = 2'b10; tbl.push_back(v);
    v.rdm = 0; v.f1 = 2'b01; tbl.push_back(v);
    v.rdw = 0; v.f1 = 2'b00; tbl.push_back(v);
    // rs2 from W; rs1 matches but unused
    v = z; v.rww = 3; v.rdw = 7; v.rs1e = 7; v.rs2e = 7; v.rre = 2'b01; v.f2 = 2'b01; tbl.push_back(v);
    // M matches but is not writing
    v = z; v.rdm = 9; v.rww = 2; v.rdw = 9; v.rs2e = 9; v.rre = 2'b01; v.f2 = 2'b01; tbl.push_back(v);
    // control transfers and miss priority
    v = z; v.be = 1; v.jd = 1; v.flush = 5'b01100; tbl.push_back(v);
    v.im = 1; v.flush = 5'b00000; v.stall = 5'b11111; tbl.push_back(v);
    v = z; v.jd = 1; v.flush = 5'b01000; tbl.push_back(v);
    v = z; v.je = 1; v.flush = 5'b01100; tbl.push_back(v);
    v = z; v.rst = 1; v.dm = 1; v.flush = 5'b11111; tbl.push_back(v);
    // load-use via rs1 and rs2
    v = z; v.m2r = 1; v.rde = 5; v.rs1d = 5; v.rrd = 2'b10; v.stall = 5'b11000; v.flush = 5'b00100; tbl.push_back(v);
    v = z; v.m2r = 4; v.rde = 5; v.rs2d = 5; v.rrd = 2'b01; v.stall = 5'b11000; v.flush = 5'b00100; tbl.push_back(v);
    // non-hazards: rd=x0, operand unused, not a load, wrong operand used
    v = z; v.m2r = 1; v.rde = 0; v.rs1d = 0; v.rrd = 2'b11; tbl.push_back(v);
    v = z; v.m2r = 1; v.rde = 5; v.rs1d = 5; v.rrd = 2'b00; tbl.push_back(v);
    v = z; v.rde = 5; v.rs1d = 5; v.rrd = 2'b10; tbl.push_back(v);
    v = z; v.m2r = 1; v.rde = 5; v.rs1d = 5; v.rrd = 2'b01; tbl.push_back(v);
    // load-use beats branch; miss beats load-use
    v = z; v.m2r = 1; v.rde = 5; v.rs1d = 5; v.rrd = 2'b10; v.be = 1; v.stall = 5'b11000; v.flush = 5'b00100; tbl.push_back(v);
    v.be = 0; v.dm = 1; v.stall = 5'b11111; v.flush = 5'b00000; tbl.push_back(v);

    foreach (tbl[i]) begin
      apply(tbl[i]); #1;
      chk($sformatf("v%0d stall", i), 32'(st1), 32'(tbl[i].stall));
      chk($sformatf("v%0d flush", i), 32'(fl1), 32'(tbl[i].flush));
      chk($sformatf("v%0d fwd1", i), 32'(f11), 32'(tbl[i].f1));
      chk($sformatf("v%0d fwd2", i), 32'(f21), 32'(tbl[i].f2));
      tick();
    end

    // single bubble, then clean
    do_reset(); set_lduse(); #1;
    chk("lu1 stall", 32'(st1), 32'b11000); chk("lu1 flush", 32'(fl1), 32'b00100);
    chk("lu1 busy", 32'(b1), 0);
    tick(); apply(z); #1;
    chk("lu1 after stall", 32'(st1), 0); chk("lu1 after flush", 32'(fl1), 0);
    chk("lu1 after busy", 32'(b1), 0);

    // three bubbles with a two-cycle miss during the second; branch ignored
    do_reset(); set_lduse(); #1;
    chk("lu3 c0 stall", 32'(st3), 32'b11000); chk("lu3 c0 busy", 32'(b3), 0);
    tick(); apply(z); dm = 1'b1; #1;
    chk("lu3 c1 stall", 32'(st3), 32'b11111); chk("lu3 c1 flush", 32'(fl3), 0); chk("lu3 c1 busy", 32'(b3), 1);
    tick(); #1;
    chk("lu3 c2 stall", 32'(st3), 32'b11111); chk("lu3 c2 busy", 32'(b3), 1);
    tick(); dm = 1'b0; be = 1'b1; #1;
    chk("lu3 c3 stall", 32'(st3), 32'b11000); chk("lu3 c3 flush", 32'(fl3), 32'b00100); chk("lu3 c3 busy", 32'(b3), 1);
    tick(); be = 1'b0; #1;
    chk("lu3 c4 stall", 32'(st3), 32'b11000); chk("lu3 c4 flush", 32'(fl3), 32'b00100); chk("lu3 c4 busy", 32'(b3), 1);
    tick(); #1;
    chk("lu3 c5 stall", 32'(st3), 0); chk("lu3 c5 flush", 32'(fl3), 0); chk("lu3 c5 busy", 32'(b3), 0);

    // reset in the middle of a bubble sequence
    do_reset(); set_lduse(); tick(); apply(z); #1;
    chk("mid busy", 32'(b3), 1);
    tick(); rst = 1'b1; #1;
    chk("mid rst flush", 32'(fl3), 32'b11111); chk("mid rst stall", 32'(st3), 0);
    tick(); rst = 1'b0; #1;
    chk("post rst busy", 32'(b3), 0); chk("post rst stall", 32'(st3), 0); chk("post rst flush", 32'(fl3), 0);

    // counters: saturation at 4 bits, no wrap at 32 bits, reset clears
    do_reset(); im = 1'b1;
    repeat (10) tick();
    chk("cnt10 u1", 32'(sc1), 10); chk("cnt10 u3", sc3, 10);
    repeat (10) tick();
    chk("cnt20 u1 sat", 32'(sc1), 15); chk("cnt20 u3", sc3, 20); chk("fcnt idle", 32'(fc1), 0);
    im = 1'b0; rst = 1'b1; #1;
    chk("rst pulse flush", 32'(fl1), 32'b11111);
    tick(); rst = 1'b0;
    chk("cnt rst u1", 32'(sc1), 0); chk("cnt rst u3", sc3, 0); chk("fcnt rst", 32'(fc1), 0);
    jd = 1'b1; repeat (3) tick(); jd = 1'b0;
    chk("fcnt jal", 32'(fc1), 3); chk("scnt jal", 32'(sc1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
